// File: rtl/w4a8_gemm_axi_mem_responder_if.sv
// Reduced AXI4 signal bundle shared by the w4a8_gemm kernel master and the
// memory responder: no ID, size, burst-type or response fields.
interface w4a8_gemm_axi_mem_responder_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 512
);
    // write address channel
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_W-1:0]     awaddr;
    logic [7:0]            awlen;
    // write data channel
    logic                  wvalid;
    logic                  wready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  wlast;
    // write response channel
    logic                  bvalid;
    logic                  bready;
    // read address channel
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_W-1:0]     araddr;
    logic [7:0]            arlen;
    // read data channel
    logic                  rvalid;
    logic                  rready;
    logic [DATA_W-1:0]     rdata;
    logic                  rlast;

    modport master (
        output awvalid, awaddr, awlen,
        output wvalid, wdata, wstrb, wlast,
        output bready,
        output arvalid, araddr, arlen,
        output rready,
        input  awready, wready, bvalid, arready, rvalid, rdata, rlast
    );

    modport slave (
        input  awvalid, awaddr, awlen,
        input  wvalid, wdata, wstrb, wlast,
        input  bready,
        input  arvalid, araddr, arlen,
        input  rready,
        output awready, wready, bvalid, arready, rvalid, rdata, rlast
    );
endinterface

// File: rtl/w4a8_gemm_axi_mem_responder.sv
// AXI4 memory responder for the w4a8_gemm kernel master port. Serves INCR
// read and write bursts from a byte-enable word memory; read and write
// channels are independent with one outstanding burst each.
module w4a8_gemm_axi_mem_responder #(
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 64,
    parameter int unsigned C_S_AXI_DATA_WIDTH = 512,
    parameter int unsigned C_MEM_DEPTH        = 1024
) (
    input  logic                                aclk,
    input  logic                                aresetn,
    w4a8_gemm_axi_mem_responder_if.slave        s_axi,
    output logic                                err_wlast
);
    localparam int unsigned NBYTES = C_S_AXI_DATA_WIDTH / 8;
    localparam int unsigned OFFS_W = $clog2(NBYTES);
    localparam int unsigned IDX_W  = $clog2(C_MEM_DEPTH);

    localparam logic [0:0] R_IDLE  = 1'b0;
    localparam logic [0:0] R_BURST = 1'b1;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    logic [C_S_AXI_DATA_WIDTH-1:0] mem [C_MEM_DEPTH];

    // read side
    logic [0:0]       rd_state;
    logic [0:0]       rd_state_nxt;
    logic [IDX_W-1:0] rd_idx;
    logic [7:0]       rd_cnt;
    logic             arready_q;
    logic             ar_hs;
    logic             r_hs;

    // write side
    logic [1:0]       wr_state;
    logic [1:0]       wr_state_nxt;
    logic [IDX_W-1:0] wr_idx;
    logic [7:0]       wr_cnt;
    logic             awready_q;
    logic             aw_hs;
    logic             w_hs;
    logic             b_hs;

    // Address bits outside the word index are ignored by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi.awaddr, s_axi.araddr};

    assign ar_hs = s_axi.arvalid && arready_q;
    assign r_hs  = (rd_state == R_BURST) && s_axi.rready;
    assign aw_hs = s_axi.awvalid && awready_q;
    assign w_hs  = (wr_state == W_DATA) && s_axi.wvalid;
    assign b_hs  = (wr_state == W_RESP) && s_axi.bready;

    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = (rd_state == R_BURST);
    assign s_axi.rlast   = (rd_state == R_BURST) && (rd_cnt == 8'd0);
    assign s_axi.rdata   = (rd_state == R_BURST) ? mem[rd_idx] : '0;

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = (wr_state == W_DATA);
    assign s_axi.bvalid  = (wr_state == W_RESP);

    // Read FSM next state: one burst at a time, leave on the rlast handshake.
    always_comb begin
        rd_state_nxt = rd_state;
        case (rd_state)
            R_IDLE:  if (ar_hs) rd_state_nxt = R_BURST;
            R_BURST: if (r_hs && (rd_cnt == 8'd0)) rd_state_nxt = R_IDLE;
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    // Read state, burst pointer and registered arready (held low in reset).
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_state  <= R_IDLE;
            rd_idx    <= '0;
            rd_cnt    <= '0;
            arready_q <= 1'b0;
        end else begin
            rd_state  <= rd_state_nxt;
            arready_q <= (rd_state_nxt == R_IDLE);
            if (ar_hs) begin
                rd_idx <= s_axi.araddr[OFFS_W +: IDX_W];
                rd_cnt <= s_axi.arlen;
            end else if (r_hs) begin
                rd_idx <= rd_idx + IDX_W'(1);
                rd_cnt <= rd_cnt - 8'd1;
            end
        end
    end

    // Write FSM next state: beat count from awlen decides the burst end.
    always_comb begin
        wr_state_nxt = wr_state;
        case (wr_state)
            W_IDLE:  if (aw_hs) wr_state_nxt = W_DATA;
            W_DATA:  if (w_hs && (wr_cnt == 8'd0)) wr_state_nxt = W_RESP;
            W_RESP:  if (b_hs) wr_state_nxt = W_IDLE;
            default: wr_state_nxt = W_IDLE;
        endcase
    end

    // Write state, burst pointer, registered awready and sticky wlast error.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state  <= W_IDLE;
            wr_idx    <= '0;
            wr_cnt    <= '0;
            awready_q <= 1'b0;
            err_wlast <= 1'b0;
        end else begin
            wr_state  <= wr_state_nxt;
            awready_q <= (wr_state_nxt == W_IDLE);
            if (aw_hs) begin
                wr_idx <= s_axi.awaddr[OFFS_W +: IDX_W];
                wr_cnt <= s_axi.awlen;
            end else if (w_hs) begin
                wr_idx <= wr_idx + IDX_W'(1);
                wr_cnt <= wr_cnt - 8'd1;
            end
            if (w_hs && (s_axi.wlast != (wr_cnt == 8'd0))) begin
                err_wlast <= 1'b1;
            end
        end
    end

    // Byte-enable memory write; contents survive reset.
    always_ff @(posedge aclk) begin
        if (w_hs) begin
            for (int unsigned b = 0; b < NBYTES; b++) begin
                if (s_axi.wstrb[b]) begin
                    mem[wr_idx][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_w4a8_gemm_axi_mem_responder.sv
// Directed bench for w4a8_gemm_axi_mem_responder: a table of single-beat
// write/read vectors plus hand-written burst, wrap, wlast-error,
// same-word concurrency and mid-burst reset sequences.
module tb_w4a8_gemm_axi_mem_responder;
    logic aclk;
    logic aresetn;
    logic err_wlast;

    int n_checks = 0;
    int n_fail   = 0;

    logic [511:0] wbuf [256];
    logic [63:0]  sbuf [256];
    logic [511:0] ebuf [256];

    typedef struct {
        logic [63:0]  waddr;
        logic [7:0]   wbyte;
        logic [63:0]  wstrb;
        logic [63:0]  raddr;
        logic [511:0] exp;
    } vec_t;

    vec_t vecs [6];

    w4a8_gemm_axi_mem_responder_if #(.ADDR_W(64), .DATA_W(512)) bus ();

    w4a8_gemm_axi_mem_responder #(
        .C_S_AXI_ADDR_WIDTH (64),
        .C_S_AXI_DATA_WIDTH (512),
        .C_MEM_DEPTH        (1024)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .s_axi     (bus.slave),
        .err_wlast (err_wlast)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic write_burst(input logic [63:0] addr, input int len, input int last_at);
        int n;
        @(negedge aclk);
        bus.awvalid = 1'b1;
        bus.awaddr  = addr;
        bus.awlen   = 8'(len);
        n = 0;
        while (!bus.awready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        chk("awready_wait", bus.awready, 1'b1);
        @(negedge aclk);
        bus.awvalid = 1'b0;
        chk("wready_after_aw", bus.wready, 1'b1);
        for (int b = 0; b <= len; b++) begin
            bus.wvalid = 1'b1;
            bus.wdata  = wbuf[b];
            bus.wstrb  = sbuf[b];
            bus.wlast  = (b == last_at);
            n = 0;
            while (!bus.wready && n < 50) begin
                @(negedge aclk);
                n++;
            end
            if (!bus.wready) chk($sformatf("wready_beat%0d", b), bus.wready, 1'b1);
            @(negedge aclk);
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        chk("bvalid_after_last_w", bus.bvalid, 1'b1);
        chk("wready_in_resp", bus.wready, 1'b0);
        bus.bready = 1'b1;
        @(negedge aclk);
        bus.bready = 1'b0;
        chk("bvalid_clear", bus.bvalid, 1'b0);
        chk("awready_after_b", bus.awready, 1'b1);
    endtask

    task automatic read_burst(input logic [63:0] addr, input int len, input bit toggle);
        int  n;
        int  beat;
        int  cyc;
        logic rr;
        @(negedge aclk);
        bus.arvalid = 1'b1;
        bus.araddr  = addr;
        bus.arlen   = 8'(len);
        n = 0;
        while (!bus.arready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        chk("arready_wait", bus.arready, 1'b1);
        @(negedge aclk);
        bus.arvalid = 1'b0;
        chk("rvalid_after_ar", bus.rvalid, 1'b1);
        beat = 0;
        cyc  = 0;
        while (beat <= len && cyc < 600) begin
            rr = !toggle || (cyc % 2 == 1);
            bus.rready = rr;
            chk($sformatf("rvalid[%0d]", beat), bus.rvalid, 1'b1);
            chk($sformatf("rdata[%0d]", beat), bus.rdata, ebuf[beat]);
            chk($sformatf("rlast[%0d]", beat), bus.rlast, (beat == len));
            if (rr) beat++;
            @(negedge aclk);
            cyc++;
        end
        bus.rready = 1'b0;
        chk("read_beats", beat, len + 1);
        chk("rvalid_clear", bus.rvalid, 1'b0);
        chk("arready_after_r", bus.arready, 1'b1);
    endtask

    initial begin
        // single-beat vectors: word index = addr[15:6]
        vecs[0] = '{64'h0,       8'hA5, '1,                    64'h0,  {64{8'hA5}}};
        vecs[1] = '{64'h40,      8'hFF, '1,                    64'h40, {64{8'hFF}}};
        vecs[2] = '{64'h40,      8'h00, 64'h0000_0000_0000_000F, 64'h40, {{60{8'hFF}}, {4{8'h00}}}};
        vecs[3] = '{64'h7F,      8'h11, 64'h0,                 64'h40, {{60{8'hFF}}, {4{8'h00}}}};
        vecs[4] = '{64'h1_0080,  8'h3C, '1,                    64'h80, {64{8'h3C}}};
        vecs[5] = '{64'h3F,      8'h5A, 64'hF000_0000_0000_0000, 64'h0, {{4{8'h5A}}, {60{8'hA5}}}};

        aresetn     = 1'b0;
        bus.awvalid = 1'b0;
        bus.awaddr  = '0;
        bus.awlen   = '0;
        bus.wvalid  = 1'b0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        bus.wlast   = 1'b0;
        bus.bready  = 1'b0;
        bus.arvalid = 1'b0;
        bus.araddr  = '0;
        bus.arlen   = '0;
        bus.rready  = 1'b0;

        // reset state
        repeat (3) @(negedge aclk);
        chk("rst_awready", bus.awready, 1'b0);
        chk("rst_arready", bus.arready, 1'b0);
        chk("rst_wready", bus.wready, 1'b0);
        chk("rst_bvalid", bus.bvalid, 1'b0);
        chk("rst_rvalid", bus.rvalid, 1'b0);
        chk("rst_rlast", bus.rlast, 1'b0);
        chk("rst_rdata", bus.rdata, '0);
        chk("rst_err_wlast", err_wlast, 1'b0);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("post_rst_awready", bus.awready, 1'b1);
        chk("post_rst_arready", bus.arready, 1'b1);

        // table-driven single beats
        for (int i = 0; i < 6; i++) begin
            wbuf[0] = {64{vecs[i].wbyte}};
            sbuf[0] = vecs[i].wstrb;
            write_burst(vecs[i].waddr, 0, 0);
            ebuf[0] = vecs[i].exp;
            read_burst(vecs[i].raddr, 0, 1'b0);
        end

        // 64-beat burst at 0x1000, read back with rready toggling
        for (int b = 0; b < 64; b++) begin
            wbuf[b] = {16{32'h1000_0000 + 32'(b)}};
            sbuf[b] = '1;
            ebuf[b] = {16{32'h1000_0000 + 32'(b)}};
        end
        write_burst(64'h1000, 63, 63);
        read_burst(64'h1000, 63, 1'b1);

        // wrap at the top of memory, W beat offered before AW
        for (int b = 0; b < 4; b++) begin
            wbuf[b] = {16{32'hC0DE_0000 + 32'(b)}};
            sbuf[b] = '1;
        end
        @(negedge aclk);
        bus.wvalid = 1'b1;
        bus.wdata  = wbuf[0];
        bus.wstrb  = sbuf[0];
        @(negedge aclk);
        chk("w_before_aw_stall0", bus.wready, 1'b0);
        @(negedge aclk);
        chk("w_before_aw_stall1", bus.wready, 1'b0);
        write_burst(64'hFF80, 3, 3);
        ebuf[0] = {16{32'hC0DE_0002}};
        ebuf[1] = {16{32'hC0DE_0003}};
        read_burst(64'h0, 1, 1'b0);
        ebuf[0] = {16{32'hC0DE_0000}};
        ebuf[1] = {16{32'hC0DE_0001}};
        read_burst(64'hFF80, 1, 1'b0);

        // same-word read stall while a write lands: old this cycle, new next
        wbuf[0] = {64{8'h77}};
        sbuf[0] = '1;
        write_burst(64'h4B00, 0, 0);
        @(negedge aclk);
        bus.arvalid = 1'b1;
        bus.araddr  = 64'h4B00;
        bus.arlen   = 8'd0;
        @(negedge aclk);
        bus.arvalid = 1'b0;
        bus.awvalid = 1'b1;
        bus.awaddr  = 64'h4B00;
        bus.awlen   = 8'd0;
        chk("conc_rdata_before", bus.rdata, {64{8'h77}});
        @(negedge aclk);
        bus.awvalid = 1'b0;
        chk("conc_wready", bus.wready, 1'b1);
        bus.wvalid = 1'b1;
        bus.wdata  = {64{8'h88}};
        bus.wstrb  = '1;
        bus.wlast  = 1'b1;
        chk("conc_rdata_same_cycle", bus.rdata, {64{8'h77}});
        @(negedge aclk);
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        chk("conc_rdata_after", bus.rdata, {64{8'h88}});
        chk("conc_rlast", bus.rlast, 1'b1);
        chk("conc_bvalid", bus.bvalid, 1'b1);
        bus.bready = 1'b1;
        bus.rready = 1'b1;
        @(negedge aclk);
        bus.bready = 1'b0;
        bus.rready = 1'b0;
        chk("conc_rvalid_clear", bus.rvalid, 1'b0);
        chk("conc_bvalid_clear", bus.bvalid, 1'b0);

        // wlast on beat 2 of a 4-beat burst: all 4 beats accepted, error sticks
        chk("err_wlast_clean", err_wlast, 1'b0);
        for (int b = 0; b < 4; b++) begin
            wbuf[b] = {16{32'hD00D_0000 + 32'(b)}};
            sbuf[b] = '1;
        end
        write_burst(64'h9600, 3, 1);
        chk("err_wlast_set", err_wlast, 1'b1);
        ebuf[0] = {16{32'hD00D_0000}};
        ebuf[1] = {16{32'hD00D_0001}};
        ebuf[2] = {16{32'hD00D_0002}};
        ebuf[3] = {16{32'hD00D_0003}};
        read_burst(64'h9600, 3, 1'b0);
        wbuf[0] = {64{8'h42}};
        write_burst(64'h9600, 0, 0);
        chk("err_wlast_sticky", err_wlast, 1'b1);

        // reset in the middle of a read and a write burst
        @(negedge aclk);
        bus.arvalid = 1'b1;
        bus.araddr  = 64'h7D00;
        bus.arlen   = 8'd3;
        @(negedge aclk);
        bus.arvalid = 1'b0;
        bus.awvalid = 1'b1;
        bus.awaddr  = 64'h7D00;
        bus.awlen   = 8'd3;
        @(negedge aclk);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b1;
        bus.wdata   = {64{8'hE1}};
        bus.wstrb   = '1;
        @(negedge aclk);
        bus.wdata = {64{8'hE2}};
        chk("mid_rvalid_pre", bus.rvalid, 1'b1);
        chk("mid_wready_pre", bus.wready, 1'b1);
        #2;
        aresetn = 1'b0;
        #1;
        chk("mid_rst_awready", bus.awready, 1'b0);
        chk("mid_rst_arready", bus.arready, 1'b0);
        chk("mid_rst_wready", bus.wready, 1'b0);
        chk("mid_rst_bvalid", bus.bvalid, 1'b0);
        chk("mid_rst_rvalid", bus.rvalid, 1'b0);
        chk("mid_rst_rlast", bus.rlast, 1'b0);
        chk("mid_rst_rdata", bus.rdata, '0);
        chk("mid_rst_err_wlast", err_wlast, 1'b0);
        bus.wvalid = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("mid_post_awready", bus.awready, 1'b1);
        chk("mid_post_arready", bus.arready, 1'b1);
        chk("mid_post_bvalid", bus.bvalid, 1'b0);
        chk("mid_post_wready", bus.wready, 1'b0);
        ebuf[0] = {64{8'hE1}};
        read_burst(64'h7D00, 0, 1'b0);
        chk("mid_post_err_wlast", err_wlast, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
